enemy_health_ctrl: RTL

Tracks the current enemy's hit points and produces the fill width and visibility flag consumed by the enemy health bar renderer. It accepts spawn and damage events from game logic and converts HP to a pixel border (`hp * WIDTH / MAX_HP`) with a multi-cycle shift-subtract divider. It optionally animates the bar draining one pixel per video frame. It sits directly upstream of the bar renderer and drives that renderer's `border_in` and `valid_in`.

---
 rtl/enemy_health_ctrl_if.sv | 38 +++
 rtl/enemy_health_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/enemy_health_ctrl_if.sv
// enemy_health_ctrl_if
//   Groups the game-logic event inputs and the health-bar outputs of
//   enemy_health_ctrl into one bundle.
//
//   Event side (driven by game logic / master):
//     spawn_in        - one-cycle pulse, load a new enemy at full HP
//     damage_valid_in - one-cycle pulse, damage_in valid this cycle
//     damage_in       - HP to subtract (HPW bits)
//     frame_tick_in   - one-cycle pulse per video frame
//   Status side (driven by the controller / slave):
//     hp_out          - current HP
//     border_out      - bar fill width in pixels (11 bits)
//     valid_out       - bar visible
//     defeated_out    - one-cycle pulse when HP reaches 0
//     busy_out        - HP-to-pixel divider running
interface enemy_health_ctrl_if #(
  parameter int HPW = 8
);
  logic           spawn_in;
  logic           damage_valid_in;
  logic [HPW-1:0] damage_in;
  logic           frame_tick_in;
  logic [HPW-1:0] hp_out;
  logic [10:0]    border_out;
  logic           valid_out;
  logic           defeated_out;
  logic           busy_out;

  modport master (
    output spawn_in, damage_valid_in, damage_in, frame_tick_in,
    input  hp_out, border_out, valid_out, defeated_out, busy_out
  );

  modport slave (
    input  spawn_in, damage_valid_in, damage_in, frame_tick_in,
    output hp_out, border_out, valid_out, defeated_out, busy_out
  );
endinterface

// File: rtl/enemy_health_ctrl.sv
// enemy_health_ctrl
//   Tracks the current enemy's HP and converts it to a health-bar fill
//   width border = floor(hp * WIDTH / MAX_HP) with a restoring
//   shift-subtract divider producing one quotient bit per cycle.
//
//   Ports:
//     clk_in - system clock
//     rst_in - synchronous active-high reset
//     bus    - enemy_health_ctrl_if.slave (events in, bar status out)
//
//   Optional feature macro: HEALTH_DRAIN_ANIM_EN
//     defined   - the bar drains toward the new target one pixel per
//                 frame_tick_in
//     undefined - the bar jumps to the new target one cycle after the
//                 divider writes it; frame_tick_in is ignored
module enemy_health_ctrl #(
  parameter int MAX_HP = 100,
  parameter int WIDTH  = 96,
  parameter int HPW    = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  enemy_health_ctrl_if.slave        bus
);

  localparam int QW = $clog2(MAX_HP * WIDTH + 1);  // dividend / quotient width
  localparam int RW = $clog2(MAX_HP + 1) + 1;      // partial remainder width
  localparam int CW = $clog2(QW + 1);              // iteration counter width

  typedef enum logic {IDLE, DIV} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [HPW-1:0]  r_hp;
  logic [10:0]     r_target;
  logic [10:0]     r_border;
  logic [RW-1:0]   r_rem;
  logic [QW-1:0]   r_quo;      // holds the dividend, shifted out as quotient bits shift in
  logic [CW-1:0]   r_cnt;
  logic            r_defeated;

  logic            w_accept;
  logic [HPW-1:0]  w_hp_new;
  logic [QW-1:0]   w_prod;
  logic [RW:0]     w_rem_sh;
  logic            w_ge;
  logic [RW-1:0]   w_rem_next;
  logic [QW-1:0]   w_quo_next;
  logic            w_last;
  logic            w_busy;

  // Damage is only taken by a live enemy; spawn in the same cycle wins.
  assign w_accept = bus.damage_valid_in && (r_hp != '0) && !bus.spawn_in;
  assign w_hp_new = (bus.damage_in >= r_hp) ? '0 : r_hp - bus.damage_in;
  assign w_prod   = QW'(w_hp_new) * QW'(WIDTH);

  // One restoring-division step: bring in the next dividend bit, subtract
  // the divisor if it fits, and record the quotient bit at the LSB.
  assign w_rem_sh   = {r_rem, r_quo[QW-1]};
  assign w_ge       = (w_rem_sh >= (RW+1)'(MAX_HP));
  assign w_rem_next = w_ge ? RW'(w_rem_sh - (RW+1)'(MAX_HP)) : RW'(w_rem_sh);
  assign w_quo_next = {r_quo[QW-2:0], w_ge};
  assign w_last     = (r_cnt == CW'(QW - 1));

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state and status outputs
  always_comb begin
    w_state_next = r_state;
    w_busy       = (r_state == DIV);
    if (bus.spawn_in)                  w_state_next = IDLE;
    else if (w_accept)                 w_state_next = DIV;
    else if (r_state == DIV && w_last) w_state_next = IDLE;
  end

  // HP, divider and bar registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hp       <= '0;
      r_target   <= '0;
      r_border   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      r_defeated <= 1'b0;
    end else begin
      r_defeated <= w_accept && (w_hp_new == '0);
      if (bus.spawn_in) begin
        r_hp     <= HPW'(MAX_HP);
        r_target <= 11'(WIDTH);
        r_border <= 11'(WIDTH);
      end else begin
`ifdef HEALTH_DRAIN_ANIM_EN
        // Growth (spawn only) is immediate; shrinking is paced by frames.
        if (r_target > r_border)
          r_border <= r_target;
        else if (bus.frame_tick_in && (r_border > r_target))
          r_border <= r_border - 11'd1;
`else
        r_border <= r_target;
`endif
        if (w_accept) begin
          // A new hit restarts the division from the fresh HP.
          r_hp  <= w_hp_new;
          r_rem <= '0;
          r_quo <= w_prod;
          r_cnt <= '0;
        end else if (r_state == DIV) begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_target <= 11'(w_quo_next);
        end
      end
    end
  end

`ifndef HEALTH_DRAIN_ANIM_EN
  logic w_unused_tick;
  assign w_unused_tick = bus.frame_tick_in;
`endif

  assign bus.hp_out       = r_hp;
  assign bus.border_out   = r_border;
  assign bus.valid_out    = (r_hp != '0) || (r_border != '0);
  assign bus.defeated_out = r_defeated;
  assign bus.busy_out     = w_busy;

endmodule
